// File: rtl/reg_axi_regfile.sv
// ---------------------------------------------------------------------------
// reg_axi_regfile
//
// This module is an AXI-style register-bus slave that connects one write
// channel pair (AW/W -> B) and one read channel pair (AR -> R) to a bank of
// NUM_REGS software registers.
//
// Channel handshakes
//   Every channel uses valid/ready. A transfer happens on a rising clock edge
//   where valid and ready are both high and clk_en is high. A source that has
//   raised valid keeps its payload stable until that edge. This slave's
//   bvalid and rvalid, once raised, stay high with a stable payload until
//   bready or rready is seen with clk_en high.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   clk_en            request-side enable; when low, no handshakes, state holds
//   aw*/w*            write address and write data channels
//   b*                write response channel (0 OKAY, 2 SLVERR, 3 DECERR)
//   ar*               read address channel
//   r*                read data/response channel
//   reg_q             flattened register contents, reg i at [i*DWID +: DWID]
//   reg_wr_pulse      one-cycle pulse per register after an accepted write
//   hw_status         hardware-fed read data for read-only registers
// ---------------------------------------------------------------------------
module reg_axi_regfile #(
    parameter int                    DWID      = 32,
    parameter int                    AWID      = 32,
    parameter int                    TID_W     = 8,
    parameter int                    NUM_REGS  = 16,
    parameter logic [AWID-1:0]       BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
    parameter logic [DWID-1:0]       RST_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic [AWID-1:0]          awaddr,
    input  logic [TID_W-1:0]         awid,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DWID-1:0]          wdata,
    input  logic [DWID/8-1:0]        wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic [TID_W-1:0]         bid,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [AWID-1:0]          araddr,
    input  logic [TID_W-1:0]         arid,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DWID-1:0]          rdata,
    output logic [1:0]               rresp,
    output logic [TID_W-1:0]         rid,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*DWID-1:0] reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    input  logic [NUM_REGS*DWID-1:0] hw_status
);

    localparam int NB    = DWID / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // This function returns 1 when the address lands inside the register
    // window. The byte-offset bits are ignored.
    function automatic logic addr_hit(input logic [AWID-1:0] addr);
        logic [AWID-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> LSB) < AWID'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AWID-1:0] addr);
        logic [AWID-1:0] sh;
        sh = (addr - BASE_ADDR) >> LSB;
        return IDX_W'(sh);
    endfunction

    // The readies are held low during reset. They rise on the first clock
    // edge after reset is released.
    logic alive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write path: one-entry AW and W buffers feeding a single commit point
    // ------------------------------------------------------------------
    logic              aw_full;
    logic [AWID-1:0]   aw_addr_q;
    logic [TID_W-1:0]  aw_id_q;
    logic              w_full;
    logic [DWID-1:0]   w_data_q;
    logic [NB-1:0]     w_strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [AWID-1:0]   c_addr;
    logic [TID_W-1:0]  c_id;
    logic [DWID-1:0]   c_data;
    logic [NB-1:0]     c_strb;
    logic              c_hit;
    logic [IDX_W-1:0]  c_idx;
    logic              c_ro;
    logic [1:0]        c_resp;
    logic [NUM_REGS-1:0] wr_en;

    assign awready = clk_en & alive & ~aw_full;
    assign wready  = clk_en & alive & ~w_full;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    // A commit takes each half either from its buffer or directly from this
    // cycle's handshake. Because a full buffer blocks its own channel, the
    // two sources never compete.
    assign commit = clk_en & (aw_full | aw_hs) & (w_full | w_hs) & (~bvalid | bready);

    assign c_addr = aw_full ? aw_addr_q : awaddr;
    assign c_id   = aw_full ? aw_id_q   : awid;
    assign c_data = w_full  ? w_data_q  : wdata;
    assign c_strb = w_full  ? w_strb_q  : wstrb;

    assign c_hit  = addr_hit(c_addr);
    assign c_idx  = addr_idx(c_addr);
    assign c_ro   = c_hit & RO_MASK[c_idx];
    assign c_resp = !c_hit ? RESP_DECERR : (c_ro ? RESP_SLVERR : RESP_OKAY);
    assign wr_en  = (commit & c_hit & ~c_ro) ? (NUM_REGS'(1) << c_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr;
                aw_id_q   <= awid;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    // B slot. A new commit may reuse the slot in the same cycle that the old
    // response is taken, so writes can complete back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= '0;
            bid    <= '0;
        end else if (clk_en) begin
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= c_resp;
                bid    <= c_id;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // wr_en is already qualified by clk_en through commit, so the pulse is
    // 0 whenever the block is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_wr_pulse <= '0;
        else        reg_wr_pulse <= wr_en;
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [DWID-1:0] rd_src [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            // A read-only register has no storage. Its readback is hw_status.
            assign reg_q[i*DWID +: DWID] = RST_VAL;
            assign rd_src[i]             = hw_status[i*DWID +: DWID];
        end else begin : g_rw
            logic [DWID-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= RST_VAL;
                end else if (wr_en[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (c_strb[b]) q[b*8 +: 8] <= c_data[b*8 +: 8];
                    end
                end
            end

            assign reg_q[i*DWID +: DWID] = q;
            assign rd_src[i]             = q;
        end
    end

    // ------------------------------------------------------------------
    // Read path: single registered response slot
    // ------------------------------------------------------------------
    logic             ar_hs;
    logic             r_hit;
    logic [IDX_W-1:0] r_idx;
    logic [DWID-1:0]  r_data;
    logic [1:0]       r_resp;

    assign arready = clk_en & alive & (~rvalid | rready);
    assign ar_hs   = arvalid & arready;
    assign r_hit   = addr_hit(araddr);
    assign r_idx   = addr_idx(araddr);

    // rd_src shows the register value from before this edge. A write that
    // commits on the same edge is therefore not visible to this read.
    assign r_data = r_hit ? rd_src[r_idx] : '0;
    assign r_resp = !r_hit ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
            rid    <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= r_data;
            rresp  <= r_resp;
            rid    <= arid;
        end else if (clk_en & rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule
